// File: rtl/alu16_seq.sv
// Two-pass 16-bit arithmetic sequencer (ADD HL,rr / INC rr / DEC rr / ADD SP,e8)
// built around an external combinational 8-bit ALU.
module alu16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] a16,
  input  logic [15:0] b16,
  input  logic [7:0]  flagsIn,
  output logic        busy,
  output logic        done,
  output logic [15:0] res16,
  output logic [7:0]  flagsRes,
  output logic [7:0]  aluA,
  output logic [7:0]  aluB,
  output logic [3:0]  aluOp,
  output logic        aluCarry,
  input  logic [7:0]  aluRes,
  input  logic [7:0]  aluFlags
);

  localparam logic [1:0] OP_ADD16 = 2'b00;
  localparam logic [1:0] OP_INC16 = 2'b01;
  localparam logic [1:0] OP_DEC16 = 2'b10;
  localparam logic [1:0] OP_ADDSP = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_ADC = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_SBC = 4'b0011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [1:0]  r_op;
  logic [7:0]  r_fin;
  logic [7:0]  r_res_lo;
  logic        r_h_lo;
  logic        r_c_lo;
  logic [7:0]  w_b_lo;
  logic [7:0]  w_b_hi;
  logic [7:0]  w_flags_new;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_LO;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LO:    w_next = S_HI;
      S_HI:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand B bytes per operation; INC/DEC step by one, ADDSP sign-extends e8
  always_comb begin
    w_b_lo = 8'h00;
    w_b_hi = 8'h00;
    case (r_op)
      OP_ADD16: begin
        w_b_lo = r_b[7:0];
        w_b_hi = r_b[15:8];
      end
      OP_INC16, OP_DEC16: begin
        w_b_lo = 8'h01;
        w_b_hi = 8'h00;
      end
      OP_ADDSP: begin
        w_b_lo = r_b[7:0];
        w_b_hi = {8{r_b[7]}};
      end
      default: begin
        w_b_lo = r_b[7:0];
        w_b_hi = r_b[15:8];
      end
    endcase
  end

  // Drive to alu8: pure decode of state and latched operands
  always_comb begin
    aluA     = 8'h00;
    aluB     = 8'h00;
    aluOp    = ALU_ADD;
    aluCarry = 1'b0;
    case (r_state)
      S_LO: begin
        aluA  = r_a[7:0];
        aluB  = w_b_lo;
        aluOp = (r_op == OP_DEC16) ? ALU_SUB : ALU_ADD;
      end
      S_HI: begin
        aluA     = r_a[15:8];
        aluB     = w_b_hi;
        aluOp    = (r_op == OP_DEC16) ? ALU_SBC : ALU_ADC;
        aluCarry = r_c_lo;
      end
      default: begin
        aluA     = 8'h00;
        aluB     = 8'h00;
        aluOp    = ALU_ADD;
        aluCarry = 1'b0;
      end
    endcase
  end

  // Final F value, valid while in HI (uses the live high-pass H/C from alu8)
  always_comb begin
    w_flags_new = 8'h00;
    case (r_op)
      OP_ADD16: w_flags_new = {r_fin[7], 1'b0, aluFlags[5], aluFlags[4], 4'b0000};
      OP_INC16: w_flags_new = {r_fin[7:4], 4'b0000};
      OP_DEC16: w_flags_new = {r_fin[7:4], 4'b0000};
      OP_ADDSP: w_flags_new = {2'b00, r_h_lo, r_c_lo, 4'b0000};
      default:  w_flags_new = {r_fin[7:4], 4'b0000};
    endcase
  end

  // Operand latch, low-pass capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= 16'h0000;
      r_b      <= 16'h0000;
      r_op     <= 2'b00;
      r_fin    <= 8'h00;
      r_res_lo <= 8'h00;
      r_h_lo   <= 1'b0;
      r_c_lo   <= 1'b0;
      res16    <= 16'h0000;
      flagsRes <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a16;
            r_b   <= b16;
            r_op  <= op;
            r_fin <= flagsIn;
          end
        end
        S_LO: begin
          r_res_lo <= aluRes;
          r_h_lo   <= aluFlags[5];
          r_c_lo   <= aluFlags[4];
        end
        S_HI: begin
          res16    <= {aluRes, r_res_lo};
          flagsRes <= w_flags_new;
        end
        default: begin
          r_res_lo <= r_res_lo;
        end
      endcase
    end
  end

  // Status outputs registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (w_next != S_IDLE);
      done <= (w_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_alu16_seq.sv
// Scoreboard bench for alu16_seq with a behavioural alu8 closing the loop.
module tb_alu16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [7:0]  flagsIn;
  logic        busy;
  logic        done;
  logic [15:0] res16;
  logic [7:0]  flagsRes;
  logic [7:0]  aluA;
  logic [7:0]  aluB;
  logic [3:0]  aluOp;
  logic        aluCarry;
  logic [7:0]  aluRes;
  logic [7:0]  aluFlags;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int n_issued = 0;
  logic [23:0] exp_q[$];

  alu16_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a16(a16), .b16(b16),
    .flagsIn(flagsIn), .busy(busy), .done(done), .res16(res16), .flagsRes(flagsRes),
    .aluA(aluA), .aluB(aluB), .aluOp(aluOp), .aluCarry(aluCarry),
    .aluRes(aluRes), .aluFlags(aluFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // alu8 behaviour: {flagsOut, res}
  function automatic logic [15:0] alu8_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] o, input logic cin);
    logic       c;
    logic [8:0] s;
    logic [4:0] hs;
    logic       sub;
    c   = (o == 4'b0001 || o == 4'b0011) ? cin : 1'b0;
    sub = (o == 4'b0010 || o == 4'b0011);
    if (sub) begin
      s  = {1'b0, a} - {1'b0, b} - {8'h00, c};
      hs = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'h0, c};
    end else begin
      s  = {1'b0, a} + {1'b0, b} + {8'h00, c};
      hs = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, c};
    end
    return {(s[7:0] == 8'h00), sub, hs[4], s[8], 4'b0000, s[7:0]};
  endfunction

  assign {aluFlags, aluRes} = alu8_model(aluA, aluB, aluOp, aluCarry);

  // Whole-word reference: {flags, result}
  function automatic logic [23:0] ref_op(input logic [1:0] o, input logic [15:0] a,
                                         input logic [15:0] b, input logic [7:0] fin);
    logic [16:0] s17;
    logic [12:0] h13;
    logic [4:0]  h5;
    logic [8:0]  c9;
    logic [15:0] ext;
    case (o)
      2'b00: begin
        s17 = {1'b0, a} + {1'b0, b};
        h13 = {1'b0, a[11:0]} + {1'b0, b[11:0]};
        return {fin[7], 1'b0, h13[12], s17[16], 4'b0000, s17[15:0]};
      end
      2'b01: return {fin[7:4], 4'b0000, a + 16'h0001};
      2'b10: return {fin[7:4], 4'b0000, a - 16'h0001};
      default: begin
        ext = {{8{b[7]}}, b[7:0]};
        h5  = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        c9  = {1'b0, a[7:0]} + {1'b0, b[7:0]};
        return {2'b00, h5[4], c9[8], 4'b0000, a + ext};
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected response
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst_n && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("res16", 32'(res16), 32'(e[15:0]));
        chk("flagsRes", 32'(flagsRes), 32'(e[23:16]));
      end
    end
  end

  // Issue one op and check cycle-level behaviour; noise keeps start high with other operands
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] fin, input logic [15:0] er, input logic [7:0] ef,
                        input bit noise);
    logic [7:0] bl, bh;
    logic [8:0] c9;
    logic       chi;
    bl = (o == 2'b00 || o == 2'b11) ? b[7:0] : 8'h01;
    bh = (o == 2'b00) ? b[15:8] : (o == 2'b11) ? {8{b[7]}} : 8'h00;
    c9 = {1'b0, a[7:0]} + {1'b0, bl};
    chi = (o == 2'b10) ? (a[7:0] == 8'h00) : c9[8];
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    start = 1'b1; op = o; a16 = a; b16 = b; flagsIn = fin;
    exp_q.push_back({ef, er});
    n_issued++;
    @(negedge clk);
    start = noise; op = o ^ 2'b11; a16 = $urandom; b16 = $urandom; flagsIn = $urandom;
    chk("lo_busy", 32'(busy), 32'd1);
    chk("lo_done", 32'(done), 32'd0);
    chk("lo_aluA", 32'(aluA), 32'(a[7:0]));
    chk("lo_aluB", 32'(aluB), 32'(bl));
    chk("lo_aluOp", 32'(aluOp), (o == 2'b10) ? 32'd2 : 32'd0);
    chk("lo_aluCarry", 32'(aluCarry), 32'd0);
    @(negedge clk);
    chk("hi_busy", 32'(busy), 32'd1);
    chk("hi_done", 32'(done), 32'd0);
    chk("hi_aluA", 32'(aluA), 32'(a[15:8]));
    chk("hi_aluB", 32'(aluB), 32'(bh));
    chk("hi_aluOp", 32'(aluOp), (o == 2'b10) ? 32'd3 : 32'd1);
    chk("hi_aluCarry", 32'(aluCarry), 32'(chi));
    @(negedge clk);
    chk("dn_busy", 32'(busy), 32'd1);
    chk("dn_done", 32'(done), 32'd1);
    chk("dn_alu_idle", 32'({aluA, aluB, aluOp, aluCarry}), 32'd0);
    if (noise) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [15:0] ra, rb;
    logic [7:0]  rf;
    logic [23:0] rx;
    int          d0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a16 = 16'h0000; b16 = 16'h0000; flagsIn = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res16", 32'(res16), 32'd0);
    chk("rst_flags", 32'(flagsRes), 32'd0);
    chk("rst_alu", 32'({aluA, aluB, aluOp, aluCarry}), 32'd0);
    rst_n = 1'b1;

    run_op(2'b00, 16'h0FFF, 16'h0001, 8'h80, 16'h1000, 8'hA0, 1'b0);
    run_op(2'b00, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h30, 1'b0);
    run_op(2'b01, 16'hFFFF, 16'h1234, 8'hF0, 16'h0000, 8'hF0, 1'b0);
    run_op(2'b10, 16'h0000, 16'h5678, 8'h50, 16'hFFFF, 8'h50, 1'b0);
    run_op(2'b11, 16'hFFF8, 16'hAB08, 8'hF0, 16'h0000, 8'h30, 1'b0);
    run_op(2'b11, 16'h0000, 16'h00FF, 8'h00, 16'hFFFF, 8'h00, 1'b0);
    run_op(2'b11, 16'h1000, 16'h7F80, 8'hC0, 16'h0F80, 8'h00, 1'b0);
    run_op(2'b00, 16'h8F88, 16'h8088, 8'h80, 16'h1010, 8'hB0, 1'b1);

    // Abort during HI: no done, outputs back to reset values at once
    @(negedge clk);
    start = 1'b1; op = 2'b00; a16 = 16'h1234; b16 = 16'h1111; flagsIn = 8'h80;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_res16", 32'(res16), 32'd0);
    chk("abort_flags", 32'(flagsRes), 32'd0);
    chk("abort_alu", 32'({aluA, aluB, aluOp, aluCarry}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    chk("abort_done_count", 32'(n_done), 32'(d0));

    for (int i = 0; i < 200; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rf = 8'($urandom);
      rx = ref_op(ro, ra, rb, rf);
      run_op(ro, ra, rb, rf, rx[15:0], rx[23:16], 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("final_busy", 32'(busy), 32'd0);
    chk("done_count", 32'(n_done), 32'(n_issued));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
